// File: rtl/audio_packet_scheduler.sv
// HDMI data-island packet scheduler: buffers PCM sample frames and picks one packet type per slot.
// Optional feature macro: PACKET_SCHEDULER_PARTIAL_AUDIO_EN (allows partial layout-0 audio packets).
module audio_packet_scheduler #(
    parameter int AUDIO_BIT_WIDTH  = 16,
    parameter int NUM_CHANNELS     = 2,
    parameter int FIFO_DEPTH       = 8,
    parameter int INFOFRAME_PERIOD = 1
) (
    input  logic                                    clk_pixel,
    input  logic                                    reset_n,
    input  logic                                    video_field_end,
    input  logic                                    packet_enable,
    input  logic [4:0]                              packet_pixel_counter,
    input  logic                                    sample_valid,
    output logic                                    sample_ready,
    input  logic [NUM_CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
    output logic [7:0]                              packet_type,
    output logic                                    audio_layout,
    output logic [191:0]                            audio_sample_word_packet,
    output logic [3:0]                              audio_sample_present,
    output logic [7:0]                              frame_counter,
    output logic                                    overflow
);

    localparam int   SW      = NUM_CHANNELS * AUDIO_BIT_WIDTH;
    localparam int   AW      = $clog2(FIFO_DEPTH);
    localparam int   CW      = AW + 1;
    localparam logic LAYOUT1 = (NUM_CHANNELS == 8);

    localparam logic [7:0] PT_NULL     = 8'h00;
    localparam logic [7:0] PT_ACR      = 8'h01;
    localparam logic [7:0] PT_AUDIO    = 8'h02;
    localparam logic [7:0] PT_AVI      = 8'h82;
    localparam logic [7:0] PT_SPD      = 8'h83;
    localparam logic [7:0] PT_AUDIO_IF = 8'h84;

`ifdef PACKET_SCHEDULER_PARTIAL_AUDIO_EN
    localparam int L0_MIN = 1;
`else
    localparam int L0_MIN = 4;
`endif
    localparam logic [CW-1:0] AUDIO_MIN = CW'(LAYOUT1 ? 1 : L0_MIN);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    logic [SW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic [7:0]      type_q, type_d;
    logic [3:0]      present_q, present_d;
    logic [191:0]    words_q, words_d;
    logic [7:0]      frame_q, frame_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      flags_q, flags_d;   // {audio IF, AVI, SPD}
    logic [1:0]      field_q, field_d;

    logic            push;
    logic [2:0]      pop_n;
    logic [2:0]      avail_n;
    logic [3:0]      present_c;
    logic [2:0]      frame_inc;
    logic [8:0]      frame_sum;
    logic [191:0]    pack_c;

    function automatic logic [23:0] place(input logic [AUDIO_BIT_WIDTH-1:0] s);
        logic [23:0] r;
        r = '0;
        r[23 -: AUDIO_BIT_WIDTH] = s;
        return r;
    endfunction

    assign avail_n   = (count_q >= CW'(4)) ? 3'd4 : 3'(count_q);
    assign frame_inc = LAYOUT1 ? 3'd1 : 3'($countones(present_q));

    always_comb begin
        present_c = 4'b1111;
        if (!LAYOUT1) begin
            case (avail_n)
                3'd0:    present_c = 4'b0000;
                3'd1:    present_c = 4'b0001;
                3'd2:    present_c = 4'b0011;
                3'd3:    present_c = 4'b0111;
                default: present_c = 4'b1111;
            endcase
        end
    end

    // Layout 1 spreads the head frame over all subpackets; layout 0 takes one frame per subpacket.
    if (NUM_CHANNELS == 8) begin : g_layout1
        always_comb begin
            pack_c = '0;
            for (int i = 0; i < 4; i++) begin
                pack_c[i*48 +: 24]    = place(mem_q[rd_ptr_q][(2*i)*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
                pack_c[i*48+24 +: 24] = place(mem_q[rd_ptr_q][(2*i+1)*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
            end
        end
    end else begin : g_layout0
        always_comb begin
            pack_c = '0;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < avail_n) begin
                    pack_c[i*48 +: 24]    = place(mem_q[rd_ptr_q + AW'(i)][AUDIO_BIT_WIDTH-1:0]);
                    pack_c[i*48+24 +: 24] = place(mem_q[rd_ptr_q + AW'(i)][2*AUDIO_BIT_WIDTH-1:AUDIO_BIT_WIDTH]);
                end
            end
        end
    end

    always_comb begin
        push      = sample_valid && ready_q;
        pop_n     = 3'd0;
        type_d    = type_q;
        present_d = present_q;
        words_d   = words_q;
        flags_d   = flags_q;
        field_d   = field_q;
        frame_d   = frame_q;
        ovf_d     = ovf_q | (sample_valid && !ready_q);
        frame_sum = {1'b0, frame_q} + 9'(frame_inc);

        if (packet_pixel_counter == 5'd31 && type_q == PT_AUDIO) begin
            frame_d = (frame_sum >= 9'd192) ? 8'(frame_sum - 9'd192) : frame_sum[7:0];
        end

        // A field end overrides a coincident commit: nothing is popped or cleared.
        if (video_field_end) begin
            type_d    = PT_NULL;
            present_d = '0;
            words_d   = '0;
            if (int'(field_q) + 1 >= INFOFRAME_PERIOD) begin
                field_d = '0;
                flags_d = 3'b111;
            end else begin
                field_d = field_q + 2'd1;
            end
        end else if (packet_enable) begin
            present_d = '0;
            words_d   = '0;
            if (count_q >= AUDIO_MIN) begin
                type_d    = PT_AUDIO;
                present_d = present_c;
                words_d   = pack_c;
                pop_n     = LAYOUT1 ? 3'd1 : avail_n;
            end else if (flags_q[2]) begin
                type_d     = PT_AUDIO_IF;
                flags_d[2] = 1'b0;
            end else if (flags_q[1]) begin
                type_d     = PT_AVI;
                flags_d[1] = 1'b0;
            end else if (flags_q[0]) begin
                type_d     = PT_SPD;
                flags_d[0] = 1'b0;
            end else begin
                type_d = PT_ACR;
            end
        end

        count_d = count_q + CW'(push) - CW'(pop_n);
        ready_d = (count_d != DEPTH_C);
    end

    always_ff @(posedge clk_pixel) begin
        if (push) mem_q[wr_ptr_q] <= sample_word;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            type_q    <= PT_NULL;
            present_q <= '0;
            words_q   <= '0;
            frame_q   <= '0;
            ovf_q     <= 1'b0;
            flags_q   <= 3'b111;
            field_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q  <= rd_ptr_q + AW'(pop_n);
            count_q   <= count_d;
            ready_q   <= ready_d;
            type_q    <= type_d;
            present_q <= present_d;
            words_q   <= words_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            flags_q   <= flags_d;
            field_q   <= field_d;
        end
    end

    assign sample_ready             = ready_q;
    assign packet_type              = type_q;
    assign audio_layout             = LAYOUT1;
    assign audio_sample_word_packet = words_q;
    assign audio_sample_present     = present_q;
    assign frame_counter            = frame_q;
    assign overflow                 = ovf_q;

endmodule

// File: tb/tb_audio_packet_scheduler.sv
// Directed self-checking bench for audio_packet_scheduler: a 2-channel and an 8-channel instance.
module tb_audio_packet_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         fe, pe, sv;
    logic [4:0]   pix;
    logic [31:0]  sw;
    logic         ready, layout, ovf;
    logic [7:0]   ptype, fcnt;
    logic [191:0] words;
    logic [3:0]   present;

    logic         fe8, pe8, sv8;
    logic [4:0]   pix8;
    logic [127:0] sw8;
    logic         ready8, layout8, ovf8;
    logic [7:0]   ptype8, fcnt8;
    logic [191:0] words8;
    logic [3:0]   present8;

    int checks = 0;
    int errors = 0;

    audio_packet_scheduler #(.AUDIO_BIT_WIDTH(16), .NUM_CHANNELS(2), .FIFO_DEPTH(8), .INFOFRAME_PERIOD(1)) u_dut (
        .clk_pixel(clk), .reset_n(rst_n), .video_field_end(fe), .packet_enable(pe),
        .packet_pixel_counter(pix), .sample_valid(sv), .sample_ready(ready), .sample_word(sw),
        .packet_type(ptype), .audio_layout(layout), .audio_sample_word_packet(words),
        .audio_sample_present(present), .frame_counter(fcnt), .overflow(ovf));

    audio_packet_scheduler #(.AUDIO_BIT_WIDTH(16), .NUM_CHANNELS(8), .FIFO_DEPTH(8), .INFOFRAME_PERIOD(1)) u_dut8 (
        .clk_pixel(clk), .reset_n(rst_n), .video_field_end(fe8), .packet_enable(pe8),
        .packet_pixel_counter(pix8), .sample_valid(sv8), .sample_ready(ready8), .sample_word(sw8),
        .packet_type(ptype8), .audio_layout(layout8), .audio_sample_word_packet(words8),
        .audio_sample_present(present8), .frame_counter(fcnt8), .overflow(ovf8));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_commit();
        pe = 1'b1; tick(); pe = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        sv = 1'b1; sw = w; tick(); sv = 1'b0;
    endtask

    task automatic pix31();
        pix = 5'd31; tick(); pix = 5'd0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h84, 8'h82, 8'h83, 8'h01};
        tick(); tick();
        checks++; if (ptype !== 8'h00) begin errors++; $display("FAIL reset_type got %h want 00", ptype); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", fcnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (words !== 192'd0 || present !== 4'b0) begin errors++; $display("FAIL reset_data words %h present %b want 0", words, present); end
        checks++; if (layout !== 1'b0 || layout8 !== 1'b1) begin errors++; $display("FAIL layout got %b/%b want 0/1", layout, layout8); end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            do_commit();
            checks++; if (ptype !== exp_seq[i]) begin errors++; $display("FAIL reset_flags[%0d] got %h want %h", i, ptype, exp_seq[i]); end
        end
    endtask

    task automatic test_field_flags();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h84, 8'h82, 8'h83, 8'h01, 8'h01};
        fe = 1'b1; tick(); fe = 1'b0;
        checks++; if (ptype !== 8'h00) begin errors++; $display("FAIL field_end_type got %h want 00", ptype); end
        for (int i = 0; i < 5; i++) begin
            do_commit();
            checks++; if (ptype !== exp_seq[i] || present !== 4'b0) begin errors++; $display("FAIL field_flags[%0d] got %h/%b want %h/0000", i, ptype, present, exp_seq[i]); end
        end
    endtask

    task automatic test_partial();
        push(32'h2222_1111);
        push(32'h4444_3333);
        do_commit();
`ifdef PACKET_SCHEDULER_PARTIAL_AUDIO_EN
        checks++; if (ptype !== 8'h02 || present !== 4'b0011) begin errors++; $display("FAIL partial_type got %h/%b want 02/0011", ptype, present); end
        checks++; if (words !== {96'd0, 24'h444400, 24'h333300, 24'h222200, 24'h111100}) begin errors++; $display("FAIL partial_words got %h", words); end
        pix31();
        checks++; if (fcnt !== 8'd2) begin errors++; $display("FAIL partial_frame got %0d want 2", fcnt); end
`else
        checks++; if (ptype !== 8'h01 || present !== 4'b0000) begin errors++; $display("FAIL nopartial_type got %h/%b want 01/0000", ptype, present); end
        push(32'h6666_5555);
        push(32'h8888_7777);
        do_commit();
        checks++; if (ptype !== 8'h02 || present !== 4'b1111) begin errors++; $display("FAIL full_type got %h/%b want 02/1111", ptype, present); end
        checks++; if (words !== {24'h888800, 24'h777700, 24'h666600, 24'h555500, 24'h444400, 24'h333300, 24'h222200, 24'h111100}) begin errors++; $display("FAIL full_words got %h", words); end
        pix31();
        checks++; if (fcnt !== 8'd4) begin errors++; $display("FAIL full_frame got %0d want 4", fcnt); end
`endif
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h84, 8'h82, 8'h83, 8'h01};
        push(32'h0001_0001);
        push(32'h0002_0002);
        push(32'h0003_0003);
        rst_n = 1'b0;
        #1;
        checks++; if (ptype !== 8'h00 || fcnt !== 8'd0 || ready !== 1'b1) begin errors++; $display("FAIL midreset got type %h frame %0d ready %b want 00/0/1", ptype, fcnt, ready); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            do_commit();
            checks++; if (ptype !== exp_seq[i]) begin errors++; $display("FAIL midreset_seq[%0d] got %h want %h", i, ptype, exp_seq[i]); end
        end
    endtask

    task automatic test_frame_wrap();
        for (int p = 0; p < 49; p++) begin
            sv = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sw = {16'h0100 + 16'(k), 16'h0200 + 16'(k)};
                tick();
            end
            sv = 1'b0;
            do_commit();
            checks++; if (ptype !== 8'h02 || present !== 4'b1111) begin errors++; $display("FAIL wrap_pkt[%0d] got %h/%b want 02/1111", p, ptype, present); end
            if (p == 48) begin
                checks++; if (words !== {24'h010300, 24'h020300, 24'h010200, 24'h020200, 24'h010100, 24'h020100, 24'h010000, 24'h020000}) begin errors++; $display("FAIL wrap_words got %h", words); end
            end
            pix31();
            if (p == 46) begin
                checks++; if (fcnt !== 8'd188) begin errors++; $display("FAIL frame_188 got %0d want 188", fcnt); end
            end
            if (p == 47) begin
                checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL frame_wrap0 got %0d want 0", fcnt); end
            end
            if (p == 48) begin
                checks++; if (fcnt !== 8'd4) begin errors++; $display("FAIL frame_wrap4 got %0d want 4", fcnt); end
            end
        end
        do_commit();
        checks++; if (ptype !== 8'h01) begin errors++; $display("FAIL acr_after_wrap got %h want 01", ptype); end
        pix31();
        checks++; if (fcnt !== 8'd4) begin errors++; $display("FAIL frame_hold got %0d want 4", fcnt); end
    endtask

    task automatic test_fifo_full();
        sv = 1'b1;
        for (int j = 0; j < 9; j++) begin
            sw = {16'hA000 + 16'(j), 16'hB000 + 16'(j)};
            tick();
            if (j == 6) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_at7 got %b want 1", ready); end
            end
            if (j == 7) begin
                checks++; if (ready !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL full_at8 ready %b ovf %b want 0/0", ready, ovf); end
            end
            if (j == 8) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow got %b want 1", ovf); end
            end
        end
        sv = 1'b0;
        do_commit();
        checks++; if (ptype !== 8'h02 || ready !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL pop_full type %h ready %b ovf %b want 02/1/1", ptype, ready, ovf); end
        checks++; if (words !== {24'hA00300, 24'hB00300, 24'hA00200, 24'hB00200, 24'hA00100, 24'hB00100, 24'hA00000, 24'hB00000}) begin errors++; $display("FAIL pop_full_words got %h", words); end
        do_commit();
        checks++; if (words !== {24'hA00700, 24'hB00700, 24'hA00600, 24'hB00600, 24'hA00500, 24'hB00500, 24'hA00400, 24'hB00400}) begin errors++; $display("FAIL pop_second_words got %h", words); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) push({16'h0D00 + 16'(k), 16'h0E00 + 16'(k)});
        pe = 1'b1; sv = 1'b1; sw = {16'h0D04, 16'h0E04};
        tick();
        pe = 1'b0; sv = 1'b0;
        checks++; if (ptype !== 8'h02 || present !== 4'b1111) begin errors++; $display("FAIL b2b_type got %h/%b want 02/1111", ptype, present); end
        for (int k = 5; k < 8; k++) push({16'h0D00 + 16'(k), 16'h0E00 + 16'(k)});
        do_commit();
        checks++; if (words !== {24'h0D0700, 24'h0E0700, 24'h0D0600, 24'h0E0600, 24'h0D0500, 24'h0E0500, 24'h0D0400, 24'h0E0400}) begin errors++; $display("FAIL b2b_words got %h", words); end
    endtask

    task automatic test_layout1();
        for (int k = 0; k < 8; k++) sw8[k*16 +: 16] = 16'(k + 1);
        sv8 = 1'b1; tick(); sv8 = 1'b0;
        pe8 = 1'b1; tick(); pe8 = 1'b0;
        checks++; if (ptype8 !== 8'h02 || present8 !== 4'b1111) begin errors++; $display("FAIL l1_type got %h/%b want 02/1111", ptype8, present8); end
        checks++; if (words8 !== {24'h000800, 24'h000700, 24'h000600, 24'h000500, 24'h000400, 24'h000300, 24'h000200, 24'h000100}) begin errors++; $display("FAIL l1_words got %h", words8); end
        pix8 = 5'd31; tick(); pix8 = 5'd0;
        checks++; if (fcnt8 !== 8'd1) begin errors++; $display("FAIL l1_frame got %0d want 1", fcnt8); end
        for (int k = 0; k < 8; k++) sw8[k*16 +: 16] = 16'(16'h10 + k);
        sv8 = 1'b1; tick();
        for (int k = 0; k < 8; k++) sw8[k*16 +: 16] = 16'(16'h20 + k);
        tick(); sv8 = 1'b0;
        fe8 = 1'b1; pe8 = 1'b1; tick(); fe8 = 1'b0; pe8 = 1'b0;
        checks++; if (ptype8 !== 8'h00 || present8 !== 4'b0) begin errors++; $display("FAIL coincident got %h/%b want 00/0000", ptype8, present8); end
        pe8 = 1'b1; tick(); pe8 = 1'b0;
        checks++; if (ptype8 !== 8'h02 || words8[47:0] !== {24'h001100, 24'h001000}) begin errors++; $display("FAIL l1_headA got %h/%h want 02/001100001000", ptype8, words8[47:0]); end
        pe8 = 1'b1; tick(); pe8 = 1'b0;
        checks++; if (ptype8 !== 8'h02 || words8[23:0] !== 24'h002000) begin errors++; $display("FAIL l1_headB got %h/%h want 02/002000", ptype8, words8[23:0]); end
        pe8 = 1'b1; tick(); pe8 = 1'b0;
        checks++; if (ptype8 !== 8'h84 || ready8 !== 1'b1) begin errors++; $display("FAIL l1_empty got %h ready %b want 84/1", ptype8, ready8); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fe = 1'b0; pe = 1'b0; sv = 1'b0; pix = 5'd0; sw = '0;
        fe8 = 1'b0; pe8 = 1'b0; sv8 = 1'b0; pix8 = 5'd0; sw8 = '0;
        test_reset();
        test_field_flags();
        test_partial();
        test_reset_midstream();
        test_frame_wrap();
        test_fifo_full();
        test_back_to_back();
        test_layout1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
